// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: owns the FP register file, a tag-indexed in-flight
// slot table and per-register scoreboard, plus load write port, flush drain and sticky flags.
module fp_issue_ctrl #(
  parameter int FLEN         = 32,
  parameter int NUM_FREGS    = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int OPW          = 16,
  localparam int RW          = $clog2(NUM_FREGS),
  localparam int TAGW        = $clog2(MAX_INFLIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [RW-1:0]     dec_rs1_i,
  input  logic [RW-1:0]     dec_rs2_i,
  input  logic [RW-1:0]     dec_rs3_i,
  input  logic [2:0]        dec_rs_used_i,
  input  logic [RW-1:0]     dec_rd_i,
  input  logic              dec_rd_wr_i,
  input  logic [OPW-1:0]    dec_op_i,
  output logic              fpu_valid_o,
  input  logic              fpu_ready_i,
  output logic [3*FLEN-1:0] fpu_operands_o,
  output logic [OPW-1:0]    fpu_op_o,
  output logic [TAGW-1:0]   fpu_tag_o,
  input  logic              fpu_rsp_valid_i,
  output logic              fpu_rsp_ready_o,
  input  logic [FLEN-1:0]   fpu_result_i,
  input  logic [TAGW-1:0]   fpu_tag_i,
  input  logic [4:0]        fpu_status_i,
  input  logic              fpu_busy_i,
  output logic              fpu_flush_o,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [RW-1:0]     ld_waddr_i,
  input  logic [FLEN-1:0]   ld_wdata_i,
  input  logic              flush_i,
  output logic [4:0]        fflags_o,
  input  logic              fflags_clr_i,
  output logic              busy_o
);

  logic [FLEN-1:0]         rf_q [NUM_FREGS];
  logic [FLEN-1:0]         rf_d [NUM_FREGS];
  logic [MAX_INFLIGHT-1:0] slot_valid_q, slot_valid_d;
  logic [MAX_INFLIGHT-1:0] slot_wr_q, slot_wr_d;
  logic [RW-1:0]           slot_rd_q [MAX_INFLIGHT];
  logic [RW-1:0]           slot_rd_d [MAX_INFLIGHT];
  logic [NUM_FREGS-1:0]    pend_q, pend_d;
  logic [4:0]              fflags_q, fflags_d;
  logic                    drain_q, drain_d;

  logic [TAGW-1:0] free;
  logic            full, hazard, issue_ok, go, rsp_hit;

  // Lowest-index invalid slot wins allocation.
  always_comb begin
    free = '0;
    for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) free = TAGW'(i);
    end
  end

  assign full   = &slot_valid_q;
  assign hazard = (dec_rs_used_i[0] && pend_q[dec_rs1_i]) ||
                  (dec_rs_used_i[1] && pend_q[dec_rs2_i]) ||
                  (dec_rs_used_i[2] && pend_q[dec_rs3_i]) ||
                  (dec_rd_wr_i && pend_q[dec_rd_i]);
  assign issue_ok = dec_valid_i && !hazard && !full && !drain_q && !flush_i;
  assign go       = issue_ok && fpu_ready_i;
  // A flush in the same cycle cancels the response entirely.
  assign rsp_hit  = fpu_rsp_valid_i && slot_valid_q[fpu_tag_i] && !flush_i;

  assign fpu_valid_o     = issue_ok;
  assign dec_ready_o     = go;
  assign fpu_tag_o       = free;
  assign fpu_op_o        = dec_op_i;
  assign fpu_operands_o  = {rf_q[dec_rs3_i], rf_q[dec_rs2_i], rf_q[dec_rs1_i]};
  assign fpu_rsp_ready_o = 1'b1;
  assign fpu_flush_o     = flush_i;
  assign ld_ready_o      = ld_valid_i && !fpu_rsp_valid_i && !pend_q[ld_waddr_i];
  assign fflags_o        = fflags_q;
  assign busy_o          = (|slot_valid_q) || drain_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_wr_d    = slot_wr_q;
    slot_rd_d    = slot_rd_q;
    pend_d       = pend_q;
    fflags_d     = fflags_clr_i ? 5'd0 : fflags_q;
    drain_d      = drain_q && fpu_busy_i;
    if (rsp_hit) begin
      slot_valid_d[fpu_tag_i] = 1'b0;
      if (slot_wr_q[fpu_tag_i]) pend_d[slot_rd_q[fpu_tag_i]] = 1'b0;
      fflags_d = fflags_d | fpu_status_i;
    end
    if (go) begin
      slot_valid_d[free] = 1'b1;
      slot_wr_d[free]    = dec_rd_wr_i;
      slot_rd_d[free]    = dec_rd_i;
      if (dec_rd_wr_i) pend_d[dec_rd_i] = 1'b1;
    end
    if (flush_i) begin
      slot_valid_d = '0;
      pend_d       = '0;
      drain_d      = 1'b1;
    end
  end

  // Loads never coincide with a writeback since any response blocks ld_ready_o.
  always_comb begin
    rf_d = rf_q;
    if (rsp_hit && slot_wr_q[fpu_tag_i]) rf_d[slot_rd_q[fpu_tag_i]] = fpu_result_i;
    else if (ld_ready_o)                 rf_d[ld_waddr_i]           = ld_wdata_i;
  end

  for (genvar gi = 0; gi < NUM_FREGS; gi++) begin : g_rf
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rf_q[gi] <= '0;
      else       rf_q[gi] <= rf_d[gi];
    end
  end

  for (genvar gi = 0; gi < MAX_INFLIGHT; gi++) begin : g_slot
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) slot_rd_q[gi] <= '0;
      else       slot_rd_q[gi] <= slot_rd_d[gi];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      slot_wr_q    <= '0;
      pend_q       <= '0;
      fflags_q     <= '0;
      drain_q      <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_wr_q    <= slot_wr_d;
      pend_q       <= pend_d;
      fflags_q     <= fflags_d;
      drain_q      <= drain_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed scenarios plus randomized traffic, all checked
// against a behavioural model of in-flight ops, register contents and flags.
module tb_fp_issue_ctrl;
  localparam int FLEN = 32, NR = 32, MI = 4, OPW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            dec_valid_i, dec_ready_o;
  logic [4:0]      dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i;
  logic [2:0]      dec_rs_used_i;
  logic            dec_rd_wr_i;
  logic [OPW-1:0]  dec_op_i, fpu_op_o;
  logic            fpu_valid_o, fpu_ready_i;
  logic [3*FLEN-1:0] fpu_operands_o;
  logic [1:0]      fpu_tag_o, fpu_tag_i;
  logic            fpu_rsp_valid_i, fpu_rsp_ready_o;
  logic [FLEN-1:0] fpu_result_i, ld_wdata_i;
  logic [4:0]      fpu_status_i, fflags_o, ld_waddr_i;
  logic            fpu_busy_i, fpu_flush_o, ld_valid_i, ld_ready_o;
  logic            flush_i, fflags_clr_i, busy_o;

  always #5 clk_i = ~clk_i;

  fp_issue_ctrl #(.FLEN(FLEN), .NUM_FREGS(NR), .MAX_INFLIGHT(MI), .OPW(OPW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rs3_i(dec_rs3_i),
    .dec_rs_used_i(dec_rs_used_i), .dec_rd_i(dec_rd_i), .dec_rd_wr_i(dec_rd_wr_i),
    .dec_op_i(dec_op_i), .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_tag_o(fpu_tag_o),
    .fpu_rsp_valid_i(fpu_rsp_valid_i), .fpu_rsp_ready_o(fpu_rsp_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_tag_i(fpu_tag_i), .fpu_status_i(fpu_status_i),
    .fpu_busy_i(fpu_busy_i), .fpu_flush_o(fpu_flush_o),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_waddr_i(ld_waddr_i),
    .ld_wdata_i(ld_wdata_i), .flush_i(flush_i), .fflags_o(fflags_o),
    .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: the set of ops currently held by the FPU, indexed by tag.
  logic [FLEN-1:0] m_rf [NR];
  bit              m_slot_v [MI];
  logic [4:0]      m_slot_rd [MI];
  bit              m_slot_wr [MI];
  logic [4:0]      m_flags;
  bit              m_drain;

  bit              e_fpu_valid, e_dec_ready, e_ld_ready, e_busy;
  int              e_tag;
  logic [3*FLEN-1:0] e_ops;

  function automatic bit m_pend(logic [4:0] r);
    for (int t = 0; t < MI; t++)
      if (m_slot_v[t] && m_slot_wr[t] && m_slot_rd[t] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    for (int t = 0; t < MI; t++) if (!m_slot_v[t]) return t;
    return -1;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) m_rf[r] = '0;
    for (int t = 0; t < MI; t++) begin m_slot_v[t] = 0; m_slot_rd[t] = '0; m_slot_wr[t] = 0; end
    m_flags = '0;
    m_drain = 0;
  endtask

  task automatic m_eval();
    bit hz;
    hz = (dec_rs_used_i[0] && m_pend(dec_rs1_i)) || (dec_rs_used_i[1] && m_pend(dec_rs2_i)) ||
         (dec_rs_used_i[2] && m_pend(dec_rs3_i)) || (dec_rd_wr_i && m_pend(dec_rd_i));
    e_tag       = m_free();
    e_fpu_valid = dec_valid_i && !hz && (e_tag >= 0) && !m_drain && !flush_i;
    e_dec_ready = e_fpu_valid && fpu_ready_i;
    e_ld_ready  = ld_valid_i && !fpu_rsp_valid_i && !m_pend(ld_waddr_i);
    e_busy      = m_drain;
    for (int t = 0; t < MI; t++) if (m_slot_v[t]) e_busy = 1;
    e_ops = {m_rf[dec_rs3_i], m_rf[dec_rs2_i], m_rf[dec_rs1_i]};
  endtask

  task automatic m_step();
    int f;
    bit iss, hit;
    logic [4:0] nf;
    m_eval();
    f   = e_tag;
    iss = e_dec_ready;
    hit = !flush_i && fpu_rsp_valid_i && m_slot_v[fpu_tag_i];
    nf  = fflags_clr_i ? 5'd0 : m_flags;
    if (hit) begin
      nf = nf | fpu_status_i;
      if (m_slot_wr[fpu_tag_i]) m_rf[m_slot_rd[fpu_tag_i]] = fpu_result_i;
      m_slot_v[fpu_tag_i] = 0;
    end
    if (iss) begin
      m_slot_v[f] = 1; m_slot_rd[f] = dec_rd_i; m_slot_wr[f] = dec_rd_wr_i;
    end
    if (e_ld_ready) m_rf[ld_waddr_i] = ld_wdata_i;
    if (flush_i) begin
      for (int t = 0; t < MI; t++) m_slot_v[t] = 0;
      m_drain = 1;
    end else if (m_drain && !fpu_busy_i) m_drain = 0;
    m_flags = nf;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dec_valid_i = 0; dec_rs1_i = '0; dec_rs2_i = '0; dec_rs3_i = '0; dec_rs_used_i = '0;
    dec_rd_i = '0; dec_rd_wr_i = 0; dec_op_i = '0; fpu_ready_i = 0;
    fpu_rsp_valid_i = 0; fpu_result_i = '0; fpu_tag_i = '0; fpu_status_i = '0;
    fpu_busy_i = 0; ld_valid_i = 0; ld_waddr_i = '0; ld_wdata_i = '0;
    flush_i = 0; fflags_clr_i = 0;
  endtask

  task automatic set_op(logic [4:0] rs1, logic [4:0] rs2, logic [2:0] used, logic [4:0] rd, bit wr);
    dec_valid_i = 1; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rs3_i = '0;
    dec_rs_used_i = used; dec_rd_i = rd; dec_rd_wr_i = wr; fpu_ready_i = 1;
    dec_op_i = 16'(rd * 257 + 16'h0A00);
  endtask

  task automatic set_rsp(logic [1:0] tag, logic [31:0] res, logic [4:0] st);
    fpu_rsp_valid_i = 1; fpu_tag_i = tag; fpu_result_i = res; fpu_status_i = st;
  endtask

  task automatic do_load(logic [4:0] a, logic [31:0] d);
    ld_valid_i = 1; ld_waddr_i = a; ld_wdata_i = d;
    tick();
    ld_valid_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    vectors++; if (fpu_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_fpu_valid: got %b want 0", fpu_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++; if (fpu_flush_o !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", fpu_flush_o); end
    vectors++; if (fflags_o !== 5'd0) begin miscompares++; $display("FAIL reset_fflags: got %h want 00", fflags_o); end
    vectors++; if (fpu_operands_o !== '0) begin miscompares++; $display("FAIL reset_rf: got %h want 0", fpu_operands_o); end
    rst_i = 0;
    tick();
    $display("reset done");
  endtask

  task automatic test_fadd();
    do_load(5'd1, 32'h3F800000);
    do_load(5'd2, 32'h40000000);
    set_op(5'd1, 5'd2, 3'b011, 5'd3, 1);
    #1;
    vectors++; if (fpu_valid_o !== 1'b1 || dec_ready_o !== 1'b1) begin miscompares++; $display("FAIL fadd_issue: got v=%b r=%b want 1/1", fpu_valid_o, dec_ready_o); end
    vectors++; if (fpu_tag_o !== 2'd0) begin miscompares++; $display("FAIL fadd_tag: got %0d want 0", fpu_tag_o); end
    vectors++; if (fpu_operands_o[63:0] !== 64'h40000000_3F800000) begin miscompares++; $display("FAIL fadd_operands: got %h want 400000003f800000", fpu_operands_o[63:0]); end
    vectors++; if (fpu_op_o !== dec_op_i) begin miscompares++; $display("FAIL fadd_op: got %h want %h", fpu_op_o, dec_op_i); end
    tick();
    idle();
    set_rsp(2'd0, 32'h40400000, 5'd0);
    #1;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL fadd_busy_inflight: got %b want 1", busy_o); end
    tick();
    idle();
    set_op(5'd3, 5'd0, 3'b001, 5'd4, 1);
    fpu_ready_i = 0;
    #1;
    vectors++; if (fpu_operands_o[31:0] !== 32'h40400000) begin miscompares++; $display("FAIL fadd_writeback: got %h want 40400000", fpu_operands_o[31:0]); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL fadd_busy_after: got %b want 0", busy_o); end
    vectors++; if (fpu_valid_o !== 1'b1 || dec_ready_o !== 1'b0) begin miscompares++; $display("FAIL fadd_pend_clear: got v=%b r=%b want 1/0", fpu_valid_o, dec_ready_o); end
    tick();
    idle();
    $display("fadd done");
  endtask

  task automatic test_raw();
    set_op(5'd0, 5'd0, 3'b000, 5'd5, 1);
    tick();
    set_op(5'd5, 5'd0, 3'b001, 5'd6, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (dec_ready_o !== 1'b0) begin miscompares++; $display("FAIL raw_stall%0d: got %b want 0", i, dec_ready_o); end
      tick();
    end
    set_rsp(2'd0, 32'h12345678, 5'd0);
    #1;
    vectors++; if (dec_ready_o !== 1'b0) begin miscompares++; $display("FAIL raw_no_bypass: got %b want 0", dec_ready_o); end
    tick();
    fpu_rsp_valid_i = 0;
    #1;
    vectors++; if (dec_ready_o !== 1'b1) begin miscompares++; $display("FAIL raw_issue: got %b want 1", dec_ready_o); end
    vectors++; if (fpu_operands_o[31:0] !== 32'h12345678) begin miscompares++; $display("FAIL raw_operand: got %h want 12345678", fpu_operands_o[31:0]); end
    tick();
    idle();
    set_rsp(2'd0, 32'h00000066, 5'd0);
    tick();
    idle();
    $display("raw done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_op(5'd0, 5'd0, 3'b000, 5'(8 + i), 1);
      #1;
      vectors++; if (fpu_tag_o !== 2'(i) || dec_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_tag%0d: got tag=%0d r=%b want %0d/1", i, fpu_tag_o, dec_ready_o, i); end
      tick();
    end
    set_op(5'd0, 5'd0, 3'b000, 5'd12, 1);
    #1;
    vectors++; if (fpu_valid_o !== 1'b0 || dec_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_full: got v=%b r=%b want 0/0", fpu_valid_o, dec_ready_o); end
    idle();
    set_rsp(2'd2, 32'h2, 5'd0);
    tick();
    set_rsp(2'd0, 32'h0, 5'd0);
    tick();
    idle();
    set_op(5'd0, 5'd0, 3'b000, 5'd12, 1);
    #1;
    vectors++; if (fpu_tag_o !== 2'd0 || dec_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_refill: got tag=%0d r=%b want 0/1", fpu_tag_o, dec_ready_o); end
    tick();
    idle();
    for (int t = 0; t < 4; t++) begin
      if (t != 2) begin set_rsp(2'(t), 32'h100 + t, 5'd0); tick(); end
    end
    idle();
    $display("fill done");
  endtask

  task automatic test_flush();
    do_load(5'd14, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      set_op(5'd0, 5'd0, 3'b000, 5'(13 + i), 1);
      tick();
    end
    set_op(5'd13, 5'd0, 3'b001, 5'd16, 1);
    flush_i = 1; fpu_busy_i = 1;
    #1;
    vectors++; if (fpu_flush_o !== 1'b1 || fpu_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_cycle: got flush=%b v=%b want 1/0", fpu_flush_o, fpu_valid_o); end
    tick();
    flush_i = 0;
    for (int k = 0; k < 3; k++) begin
      fpu_rsp_valid_i = 0;
      if (k == 1) set_rsp(2'd1, 32'hDEADBEEF, 5'h1F);
      #1;
      vectors++; if (fpu_valid_o !== 1'b0 || busy_o !== 1'b1) begin miscompares++; $display("FAIL flush_drain%0d: got v=%b busy=%b want 0/1", k, fpu_valid_o, busy_o); end
      tick();
    end
    fpu_rsp_valid_i = 0; fpu_busy_i = 0;
    #1;
    vectors++; if (fpu_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_last_drain: got %b want 0", fpu_valid_o); end
    tick();
    #1;
    vectors++; if (dec_ready_o !== 1'b1 || fpu_tag_o !== 2'd0) begin miscompares++; $display("FAIL flush_resume: got r=%b tag=%0d want 1/0", dec_ready_o, fpu_tag_o); end
    vectors++; if (fflags_o !== m_flags) begin miscompares++; $display("FAIL flush_flags: got %h want %h", fflags_o, m_flags); end
    tick();
    idle();
    dec_rs1_i = 5'd14;
    #1;
    vectors++; if (fpu_operands_o[31:0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL flush_rf_kept: got %h want cafef00d", fpu_operands_o[31:0]); end
    set_rsp(2'd0, 32'h16, 5'd0);
    tick();
    idle();
    $display("flush done");
  endtask

  task automatic test_flags();
    fflags_clr_i = 1;
    tick();
    fflags_clr_i = 0;
    #1;
    vectors++; if (fflags_o !== 5'h00) begin miscompares++; $display("FAIL flags_clear: got %h want 00", fflags_o); end
    for (int i = 0; i < 3; i++) begin
      set_op(5'd0, 5'd0, 3'b000, 5'd20, 0);
      tick();
      idle();
      set_rsp(2'd0, 32'h0, (i == 0) ? 5'h01 : (i == 1) ? 5'h10 : 5'h04);
      fflags_clr_i = (i == 2);
      tick();
      idle();
      if (i == 1) begin
        #1;
        vectors++; if (fflags_o !== 5'h11) begin miscompares++; $display("FAIL flags_accum: got %h want 11", fflags_o); end
      end
    end
    #1;
    vectors++; if (fflags_o !== 5'h04) begin miscompares++; $display("FAIL flags_clr_with_rsp: got %h want 04", fflags_o); end
    $display("flags done");
  endtask

  task automatic test_load();
    set_op(5'd0, 5'd0, 3'b000, 5'd7, 1);
    tick();
    idle();
    ld_valid_i = 1; ld_waddr_i = 5'd7; ld_wdata_i = 32'h77770007;
    #1;
    vectors++; if (ld_ready_o !== 1'b0) begin miscompares++; $display("FAIL load_pending: got %b want 0", ld_ready_o); end
    tick();
    set_rsp(2'd0, 32'h11111111, 5'd0);
    #1;
    vectors++; if (ld_ready_o !== 1'b0) begin miscompares++; $display("FAIL load_collision: got %b want 0", ld_ready_o); end
    tick();
    fpu_rsp_valid_i = 0;
    #1;
    vectors++; if (ld_ready_o !== 1'b1) begin miscompares++; $display("FAIL load_accept: got %b want 1", ld_ready_o); end
    tick();
    idle();
    dec_rs1_i = 5'd7;
    #1;
    vectors++; if (fpu_operands_o[31:0] !== 32'h77770007) begin miscompares++; $display("FAIL load_data: got %h want 77770007", fpu_operands_o[31:0]); end
    $display("load done");
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 3000; n++) begin
      dec_valid_i = ($urandom_range(0, 9) < 7);
      dec_rs1_i = 5'($urandom_range(0, 7)); dec_rs2_i = 5'($urandom_range(0, 7));
      dec_rs3_i = 5'($urandom_range(0, 7)); dec_rs_used_i = 3'($urandom);
      dec_rd_i = 5'($urandom_range(0, 7)); dec_rd_wr_i = ($urandom_range(0, 3) != 0);
      dec_op_i = 16'($urandom); fpu_ready_i = ($urandom_range(0, 9) < 7);
      fpu_rsp_valid_i = ($urandom_range(0, 1) == 1); fpu_tag_i = 2'($urandom);
      fpu_result_i = $urandom; fpu_status_i = 5'($urandom);
      fpu_busy_i = ($urandom_range(0, 1) == 1); flush_i = ($urandom_range(0, 49) == 0);
      ld_valid_i = ($urandom_range(0, 2) == 0); ld_waddr_i = 5'($urandom_range(0, 7));
      ld_wdata_i = $urandom; fflags_clr_i = ($urandom_range(0, 19) == 0);
      m_eval();
      #1;
      bad = 0;
      vectors++;
      if (fpu_valid_o !== e_fpu_valid || dec_ready_o !== e_dec_ready) bad = 1;
      if (e_fpu_valid && fpu_tag_o !== 2'(e_tag)) bad = 1;
      if (fpu_operands_o !== e_ops || fpu_op_o !== dec_op_i) bad = 1;
      if (ld_ready_o !== e_ld_ready || busy_o !== e_busy || fpu_flush_o !== flush_i) bad = 1;
      if (fflags_o !== m_flags || fpu_rsp_ready_o !== 1'b1) bad = 1;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got v=%b r=%b tag=%0d ld=%b busy=%b fl=%h want v=%b r=%b tag=%0d ld=%b busy=%b fl=%h ops_ok=%b",
                 n, fpu_valid_o, dec_ready_o, fpu_tag_o, ld_ready_o, busy_o, fflags_o,
                 e_fpu_valid, e_dec_ready, e_tag, e_ld_ready, e_busy, m_flags, fpu_operands_o === e_ops);
      end
      tick();
    end
    idle();
    $display("random done");
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_raw();
    test_fill();
    test_flush();
    test_flags();
    test_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
Parametrised issue/writeback controller between the FP decoder and the FPU top. It owns the FP register file, tracks multiple in-flight operations through a tag-indexed slot table and per-register scoreboard, and handles valid/ready handshakes on both FPU sides. It also provides a load write port, flush recovery and sticky exception-flag accumulation.

Parameters:
FLEN, 32, FP register and operand width in bits
NUM_FREGS, 32, number of FP registers (power of two, >=2)
MAX_INFLIGHT, 4, in-flight slots (power of two, >=2); TAGW = $clog2(MAX_INFLIGHT)
OPW, 16, width of the opaque decoded-op bundle passed to the FPU

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
dec_valid_i  in  1  decoded op valid
dec_ready_o  out  1  op accepted this cycle
dec_rs1_i/dec_rs2_i/dec_rs3_i  in  $clog2(NUM_FREGS) each  source register addresses
dec_rs_used_i  in  3  per-source use mask; bit0=rs1
dec_rd_i  in  $clog2(NUM_FREGS)  destination register
dec_rd_wr_i  in  1  result is written to the FP RF
dec_op_i  in  OPW  op bundle, forwarded unchanged
fpu_valid_o  out  1  issue valid
fpu_ready_i  in  1  FPU ready
fpu_operands_o  out  3*FLEN  {rs3,rs2,rs1} data
fpu_op_o  out  OPW  forwarded op
fpu_tag_o  out  TAGW  allocated slot index
fpu_rsp_valid_i  in  1  result valid
fpu_rsp_ready_o  out  1  result accepted; tied 1
fpu_result_i  in  FLEN  result data
fpu_tag_i  in  TAGW  result tag
fpu_status_i  in  5  NV,DZ,OF,UF,NX
fpu_busy_i  in  1  FPU has ops in flight
fpu_flush_o  out  1  flush to the FPU
ld_valid_i  in  1  load write request
ld_ready_o  out  1  load write accepted
ld_waddr_i  in  $clog2(NUM_FREGS)  load destination
ld_wdata_i  in  FLEN  load data
flush_i  in  1  pipeline flush
fflags_o  out  5  sticky accumulated flags
fflags_clr_i  in  1  clear sticky flags
busy_o  out  1  any slot valid, or flush drain active

Behaviour:
- Reset, async: RF all 0; slot table invalid; scoreboard 0; fflags_o=0; drain=0. Outputs reset to fpu_valid_o=0, busy_o=0, fpu_flush_o=0.
- Slot entry: {valid, rd, rd_wr}. free = lowest-index invalid slot. full = all slots valid.
- hazard = pend[rsN] for any used source, or (dec_rd_wr_i && pend[dec_rd_i]) for WAW.
- Issue condition: go = dec_valid_i && !hazard && !full && !drain && !flush_i && fpu_ready_i.
- fpu_valid_o = dec_valid_i && !hazard && !full && !drain && !flush_i. It never depends on fpu_ready_i.
- dec_ready_o = go.
- Operands are read combinationally from the RF; fpu_tag_o = free.
- On go: slot[free] <= {1, dec_rd_i, dec_rd_wr_i}; if rd_wr, pend[rd] <= 1.
- Response with slot[tag].valid:
  - slot invalidated;
  - if rd_wr: RF[rd] <= result and pend[rd] <= 0;
  - fflags_o |= fpu_status_i.
- Response to an invalid slot is dropped: no RF write, no flag update.
- Same-cycle response free and new issue to that slot: the allocation uses pre-edge state, so the slot is not free that cycle.
- A dependent op issues no earlier than the cycle after its producer's writeback. No bypass.
- Load write: ld_ready_o = ld_valid_i && !fpu_rsp_valid_i && !pend[ld_waddr_i]. FPU writeback has priority. On accept, RF[ld_waddr_i] <= ld_wdata_i.
- flush_i:
  - next edge clears all slots and the scoreboard;
  - fpu_flush_o = flush_i, combinational;
  - drain <= 1 and stays set until a cycle with fpu_busy_i=0, then clears;
  - no issue during flush or drain;
  - responses during drain are dropped because their slots are invalid;
  - RF contents are preserved.
- fflags_clr_i: fflags_o <= status from a same-cycle valid response, else 0. New flags survive a simultaneous clear.
- Simultaneous flush and response: the flush wins; no writeback.

Test Plan:
- Single FADD: rs1=1 (0x3F800000), rs2=2 (0x40000000), rd=3, fpu_ready_i=1.
  -> fpu_valid_o, tag=0, operands correct.
  -> Response tag0 result 0x40400000: RF[3]=0x40400000, pend[3]=0, busy_o=0 the next cycle.
- RAW: op A rd=5 issued, then op B rs1=5.
  -> B stalled with dec_ready_o=0 until A's response.
  -> B issues the cycle after writeback with the new RF[5].
- Fill: 4 independent ops issued with tags 0,1,2,3.
  -> 5th stalled (full).
  -> Out-of-order responses 2,0 free those slots; the next issue gets tag 0.
- Flush with 3 slots valid, fpu_busy_i held 1 for 3 cycles.
  -> No issue during drain; late response tag1 dropped; RF unchanged.
  -> Issue resumes the cycle after fpu_busy_i=0.
- Flags: responses with status 0x01 then 0x10 -> fflags_o=0x11.
  -> fflags_clr_i together with a status-0x04 response -> fflags_o=0x04.
- Load collision: ld_valid_i to reg 7 with a same-cycle response -> ld_ready_o=0, accepted the next cycle.
  -> Load to a pending rd stalls until that rd's writeback.
